demux_router: RTL
=================

Name: demux_router

Overview:
- Opposite direction of the datapath select muxes: takes one 32-bit source stream and routes each word to one of four destination channels, chosen by a 2-bit select.
- Each destination has its own small FIFO, so a stalled consumer blocks only its own channel.
- Sits between a single producer (e.g. writeback/result bus) and up to four consumers using valid/ready handshakes.

Parameters:
- WIDTH, 32, data word width.
- DEPTH, 2, entries per channel FIFO; power of two, minimum 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  source word valid.
- in_ready  out  1  router can accept the word on in_data/in_sel this cycle.
- in_data  in  WIDTH  source word.
- in_sel  in  2  destination channel 0..3.
- out_valid  out  4  bit i: channel i head word valid.
- out_ready  in  4  bit i: consumer i takes the head word.
- out_data0..out_data3  out  WIDTH each  head word of channel 0..3.
- chan_full  out  4  bit i: channel i FIFO full (status/debug).

Behaviour:
- Accept = in_valid & in_ready. On accept, in_data is written into the FIFO of channel in_sel. No other channel changes.
- in_ready = ~chan_full[in_sel]. Purely from registered state; no combinational path from out_ready to in_ready.
  - A full channel does not accept a word in the same cycle it pops.
  - in_ready may be high while in_valid is low.
- Pop on channel i = out_valid[i] & out_ready[i]. The head advances on the next edge.
- out_valid[i] = channel i not empty. out_data_i = head entry, driven from a register or storage read (no data bypass).
- Latency: a word accepted at edge N is visible on out_valid/out_data at the next cycle (after edge N). Minimum 1 cycle.
- Ordering: FIFO order within a channel. No ordering guarantee across channels.
- Simultaneous push and pop on the same channel:
  - Not full: both occur and occupancy is unchanged.
  - Empty: the pop cannot occur because out_valid=0; the pushed word appears next cycle.
- Pushes and pops on different channels are independent and fully concurrent; up to 1 push and 4 pops per cycle.
- Occupancy counter per channel: 0..DEPTH. Read/write pointers wrap modulo DEPTH. Full = (count==DEPTH), empty = (count==0).
- Consumer violation: out_ready[i] high while out_valid[i]=0 has no effect; the count never underflows.
- data/sel are don't-care when in_valid=0. No X may propagate into state.
- Reset (asynchronous, any time including mid-transfer):
  - all counts and pointers go to 0, out_valid=4'b0000, chan_full=4'b0000, out_data0..3=0.
  - in-flight words are discarded.
  - in_ready reads 1 from the first cycle after reset deassertion.

Decomposition:
- Shared package holds:
  - localparam NUM_CHAN=4, SEL_W=2.
  - typedef chan_sel_t (logic [1:0]).
  - typedef word_t (logic [31:0]), matching the processor datapath width.
- One natural sub-module: demux_chan_fifo (WIDTH, DEPTH).
  - Ports: clk, rst, push, push_data, pop, head_data, valid, full.
  - Instantiated 4 times via generate.
- The top contains only the select decode and the in_ready mux.

Test Plan:
- Reset release, all out_ready=1; push 0x11111111 sel=2 -> next cycle out_valid=4'b0100, out_data2=0x11111111; popped the following cycle, out_valid returns to 0.
- Hold out_ready[1]=0; push 0xA0, 0xA1 to sel=1 -> chan_full[1]=1, in_ready=0 while in_sel=1. in_ready=1 when in_sel=3, and a push of 0xB0 to ch3 is accepted.
- Channel 1 full; raise out_ready[1] with in_valid=1, sel=1 -> no accept that cycle (in_ready=0). Next cycle in_ready=1, push 0xA2 -> drain order 0xA0, 0xA1, 0xA2.
- Stream 8 words 0..7 to ch0 with out_ready[0]=1 every cycle -> one word accepted and one popped per cycle, order 0..7, pointers wrap with no loss.
- Interleave sel=0,1,2,3 with all consumers stalled, then release them in order 3,2,1,0 -> each channel outputs its own word; no cross-channel corruption.
- Assert rst asynchronously (between edges) with ch0 holding 2 words -> out_valid=0 and chan_full=0 immediately; after release, first pop yields only newly pushed data.

Source files
------------

// File: rtl/demux_router_pkg.sv
// demux_router_pkg: shared channel count, select type and decode helper for the demux router
package demux_router_pkg;
  localparam int NUM_CHAN = 4;
  localparam int SEL_W = 2;
  typedef logic [SEL_W-1:0] chan_sel_t;
  typedef logic [31:0] word_t;
  function automatic logic [NUM_CHAN-1:0] sel_dec(input chan_sel_t s);
    sel_dec = NUM_CHAN'(1) << s;
  endfunction
endpackage

// File: rtl/demux_chan_fifo.sv
// demux_chan_fifo: per-channel FIFO, head word read straight from storage
module demux_chan_fifo
  import demux_router_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             valid,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full = cnt_q == CW'(DEPTH);
  assign valid = cnt_q != '0;
  assign head_data = mem_q[rd_q];
  assign do_push = push & ~full;
  assign do_pop = pop & valid;
  // Pointers wrap for free because DEPTH is a power of two.
  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = push_data;
    wr_d = do_push ? wr_q + 1'b1 : wr_q;
    rd_d = do_pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/demux_router.sv
// demux_router: routes one valid/ready source stream into four independently buffered channels
module demux_router
  import demux_router_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_data,
  input  logic [SEL_W-1:0]    in_sel,
  output logic [NUM_CHAN-1:0] out_valid,
  input  logic [NUM_CHAN-1:0] out_ready,
  output logic [WIDTH-1:0]    out_data0,
  output logic [WIDTH-1:0]    out_data1,
  output logic [WIDTH-1:0]    out_data2,
  output logic [WIDTH-1:0]    out_data3,
  output logic [NUM_CHAN-1:0] chan_full
);
  logic [WIDTH-1:0] head [NUM_CHAN];
  logic [NUM_CHAN-1:0] push;
  // in_ready depends only on registered full flags, never on out_ready.
  assign in_ready = ~chan_full[in_sel];
  assign push = sel_dec(in_sel) & {NUM_CHAN{in_valid & in_ready}};
  assign out_data0 = head[0];
  assign out_data1 = head[1];
  assign out_data2 = head[2];
  assign out_data3 = head[3];
  for (genvar g = 0; g < NUM_CHAN; g++) begin : g_chan
    demux_chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk(clk),
      .rst(rst),
      .push(push[g]),
      .push_data(in_data),
      .pop(out_ready[g]),
      .head_data(head[g]),
      .valid(out_valid[g]),
      .full(chan_full[g])
    );
  end
endmodule
